// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
// -----------------
// Single-ported 16-bit word memory shared by an instruction-fetch port and a
// load/store port. At most one access is accepted per cycle. Load/store
// normally wins a collision. A saturating starvation counter counts
// consecutive fetch stalls, and once it reaches STARVE_MAX the fetch wins
// instead. Reads have a fixed one-cycle latency. Each port's rddata register
// holds its last value between valid pulses.
//
// Parameters
//   AW             word-address width; storage is 2^AW x 16 bits
//   STARVE_MAX     fetch stalls tolerated before fetch takes priority
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   i_pc_rd        fetch read request
//   i_pc_addr      fetch word address (only [AW-1:0] used)
//   o_pc_wait      fetch request not accepted this cycle
//   o_pc_valid     fetch read data valid (one cycle after acceptance)
//   o_pc_rddata    fetch read data
//   i_ldst_rd      load request
//   i_ldst_wr      store request
//   i_ldst_addr    load/store word address (only [AW-1:0] used)
//   i_ldst_wrdata  store data
//   o_ldst_wait    load/store request not accepted this cycle
//   o_ldst_valid   load read data valid (one cycle after acceptance)
//   o_ldst_rddata  load read data
//   o_err          sticky: load and store were requested together
module cpu_mem_responder #(
    parameter int AW         = 8,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_pc_rd,
    input  logic [15:0] i_pc_addr,
    output logic        o_pc_wait,
    output logic        o_pc_valid,
    output logic [15:0] o_pc_rddata,
    input  logic        i_ldst_rd,
    input  logic        i_ldst_wr,
    input  logic [15:0] i_ldst_addr,
    input  logic [15:0] i_ldst_wrdata,
    output logic        o_ldst_wait,
    output logic        o_ldst_valid,
    output logic [15:0] o_ldst_rddata,
    output logic        o_err
);

    // The counter must be able to hold STARVE_MAX itself. A STARVE_MAX of 0
    // still needs a 1-bit counter, so that case is forced to width 1.
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

    logic [15:0]   mem [2**AW];
    logic [SW-1:0] starve_cnt;

    logic          ldst_req;
    logic          fetch_first;
    logic          pc_accept;
    logic          ldst_accept;
    logic          ldst_read;
    logic          ldst_write;
    logic [AW-1:0] pc_index;
    logic [AW-1:0] ldst_index;

    // Upper address bits alias onto the same words, so they are unused.
    generate
        if (AW < 16) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^{i_pc_addr[15:AW], i_ldst_addr[15:AW]};
        end
    endgenerate

    assign pc_index   = i_pc_addr[AW-1:0];
    assign ldst_index = i_ldst_addr[AW-1:0];

    // Arbitration. The waits depend only on this cycle's requests and the
    // starvation counter. Both ports wait while reset is held, so nothing
    // can be accepted during reset.
    always_comb begin
        ldst_req    = i_ldst_rd | i_ldst_wr;
        fetch_first = (starve_cnt >= STARVE_LIMIT);
        o_pc_wait   = 1'b1;
        o_ldst_wait = 1'b1;
        if (reset) begin
            o_pc_wait   = i_pc_rd & ldst_req & ~fetch_first;
            o_ldst_wait = ldst_req & i_pc_rd & fetch_first;
        end
    end

    // A combined rd+wr on the load/store port behaves as a store only.
    assign pc_accept   = i_pc_rd & ~o_pc_wait;
    assign ldst_accept = ldst_req & ~o_ldst_wait;
    assign ldst_read   = ldst_accept & i_ldst_rd & ~i_ldst_wr;
    assign ldst_write  = ldst_accept & i_ldst_wr;

    // Storage array. It has no reset, so its contents survive a reset.
    always_ff @(posedge clk) begin
        if (ldst_write) begin
            mem[ldst_index] <= i_ldst_wrdata;
        end
    end

    // Fetch read port. Valid is a one-cycle pulse. The data register loads
    // only on an accepted fetch, so it holds its value otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_pc_valid  <= 1'b0;
            o_pc_rddata <= 16'h0000;
        end else begin
            o_pc_valid <= pc_accept;
            if (pc_accept) begin
                o_pc_rddata <= mem[pc_index];
            end
        end
    end

    // Load read port. This port works the same way as the fetch port. A store
    // in the same cycle cannot occur because only one access is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_ldst_valid  <= 1'b0;
            o_ldst_rddata <= 16'h0000;
        end else begin
            o_ldst_valid <= ldst_read;
            if (ldst_read) begin
                o_ldst_rddata <= mem[ldst_index];
            end
        end
    end

    // Starvation counter. It counts each cycle a fetch is stalled, saturating
    // at the limit, and clears when a fetch is accepted. Idle cycles leave it
    // unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (pc_accept) begin
            starve_cnt <= '0;
        end else if (i_pc_rd && (starve_cnt < STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Protocol error flag. It is set whenever rd and wr are seen together
    // outside reset, and only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_err <= 1'b0;
        end else if (i_ldst_rd && i_ldst_wr) begin
            o_err <= 1'b1;
        end
    end

endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 Parameter AW, default 8: word-address width; storage SHALL be 2^AW words of 16 bits.
REQ-002 Parameter STARVE_MAX, default 3: consecutive fetch stalls before fetch gets priority.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low; asserting it SHALL immediately force the reset state.
REQ-005 i_pc_rd  in  1  fetch read request.
REQ-006 i_pc_addr  in  16  fetch word address.
REQ-007 o_pc_wait  out  1  fetch request not accepted this cycle.
REQ-008 o_pc_valid  out  1  fetch read data valid.
REQ-009 o_pc_rddata  out  16  fetch read data.
REQ-010 i_ldst_rd  in  1  load request.
REQ-011 i_ldst_wr  in  1  store request.
REQ-012 i_ldst_addr  in  16  load/store word address.
REQ-013 i_ldst_wrdata  in  16  store data.
REQ-014 o_ldst_wait  out  1  load/store request not accepted this cycle.
REQ-015 o_ldst_valid  out  1  load read data valid.
REQ-016 o_ldst_rddata  out  16  load read data.
REQ-017 o_err  out  1  sticky flag: rd and wr asserted together on the ldst port.

Function
REQ-018 Storage is single-ported; at most one access SHALL be accepted per cycle.
REQ-019 Only address bits [AW-1:0] SHALL select a word; upper bits are ignored and alias.
REQ-020 o_pc_wait and o_ldst_wait SHALL be combinational from the current requests and the starvation counter.
REQ-021 A request is accepted in a cycle where it is asserted and its wait is 0.
REQ-022 A waiting requester holds its request and address stable; the responder keeps no request queue.
REQ-023 Fetch and ldst request the same cycle: ldst SHALL win unless starve_cnt >= STARVE_MAX, in which case fetch SHALL win.
REQ-024 starve_cnt SHALL increment (saturating at STARVE_MAX) on each cycle the fetch request is asserted and not accepted.
REQ-025 starve_cnt SHALL clear on any cycle a fetch is accepted.
REQ-026 An accepted read SHALL pulse the port's valid for exactly one cycle, on the cycle after acceptance.
REQ-027 Read data SHALL be presented in that same cycle as valid.
REQ-028 Read latency is fixed at 1; back-to-back accepted reads SHALL produce back-to-back valid pulses.
REQ-029 rddata SHALL hold its last value while valid is 0.
REQ-030 An accepted store SHALL write storage at the accepting edge and produce no valid pulse.
REQ-031 A read of an address accepted in the cycle after a store to it SHALL return the new data.
REQ-032 i_ldst_rd and i_ldst_wr both high: treat as a store only, with no o_ldst_valid pulse, and set o_err.
REQ-033 o_err SHALL remain set until reset.
REQ-034 Idle cycles (no request) SHALL leave storage, rddata and starve_cnt unchanged.

Reset
REQ-035 On reset assertion the outputs SHALL take these values: o_pc_valid=0, o_ldst_valid=0, o_pc_rddata=0, o_ldst_rddata=0, o_err=0.
REQ-036 On reset assertion starve_cnt SHALL be 0.
REQ-037 Storage contents SHALL NOT be cleared by reset.
REQ-038 A read accepted in the cycle reset asserts SHALL produce no valid pulse after reset releases.
REQ-039 During reset, both wait outputs SHALL be 1 and no request SHALL be accepted.
REQ-040 Requests SHALL be accepted from the first rising edge after reset deasserts.

Verification
REQ-041 Store 0xBEEF to address 0x0012, then load 0x0012 the next cycle: o_ldst_valid pulses one cycle later with o_ldst_rddata=0xBEEF.
REQ-042 Fetch 0x0005 and load 0x0006 together: o_pc_wait=1 and o_ldst_valid follows; fetch is accepted next cycle and o_pc_valid follows with word 5.
REQ-043 Fetch held while ldst requests every cycle with STARVE_MAX=3: fetch is accepted on the 4th cycle and o_ldst_wait=1 that cycle.
REQ-044 Store 0x1234 to address 0x0103 with AW=8, then fetch 0x0003: o_pc_rddata=0x1234 (aliasing).
REQ-045 i_ldst_rd=i_ldst_wr=1 with data 0x00AA to address 0x0001: word written, no o_ldst_valid, o_err=1 until reset.
REQ-046 Reset asserted mid-read: valid outputs stay 0 and o_err=0; data written before reset is still readable after reset.
